// File: rtl/axi2apb_pkg.sv
// Shared types and helpers for the AXI-to-APB bridge read-response path.
package axi2apb_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Entry fields are sized for the widest supported configuration; the top zero-extends into them.
  localparam int RD_ID_W   = 16;
  localparam int RD_LANE_W = 3;

  typedef struct packed {
    logic [RD_ID_W-1:0]   id;
    logic [31:0]          data;
    logic [1:0]           resp;
    logic                 last;
    logic [RD_LANE_W-1:0] lane;
  } rd_entry_t;

  function automatic int lane_count(input int data_width);
    return (data_width / 32 < 1) ? 1 : data_width / 32;
  endfunction

endpackage

// File: rtl/axi2apb_rd_fifo.sv
// Synchronous response FIFO of rd_entry_t; pointers carry a wrap bit for full/empty.
module axi2apb_rd_fifo
  import axi2apb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  rd_entry_t din,
  output logic      full,
  output logic      empty,
  output rd_entry_t head
);

  localparam int PW = $clog2(DEPTH);

  rd_entry_t     mem [DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot the push writes into.
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

  assign head = empty ? '0 : mem[rd_ptr[PW-1:0]];

endmodule

// File: rtl/axi2apb_rd_buf.sv
// Read-response buffer of the AXI-to-APB bridge: captures APB read beats and drives the AXI R channel.
// Optional AXI2APB_RD_ERR_STICKY_EN: the first error response of a burst is repeated on its later beats.
module axi2apb_rd_buf
  import axi2apb_pkg::*;
#(
  parameter int AXI_ID_WIDTH   = 6,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int APB_ADDR_WIDTH = 12,
  parameter int DEPTH          = 4,
  parameter bit OVF_CHECK      = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [31:0]               prdata,
  input  logic                      pslverr,
  input  logic                      pready,
  input  logic                      cmd_err,
  input  logic [AXI_ID_WIDTH-1:0]   cmd_id,
  input  logic [APB_ADDR_WIDTH+3:0] cmd_addr,
  input  logic [7:0]                cmd_len,
  output logic                      rd_space,
  output logic                      rd_ovf,
  output logic                      finish_rd,
  output logic [AXI_ID_WIDTH-1:0]   RID,
  output logic [AXI_DATA_WIDTH-1:0] RDATA,
  output logic [1:0]                RRESP,
  output logic                      RLAST,
  output logic                      RVALID,
  input  logic                      RREADY
);

  localparam int LANES = lane_count(AXI_DATA_WIDTH);

  if (AXI_ID_WIDTH > RD_ID_W) begin : g_bad_id
    $error("axi2apb_rd_buf: AXI_ID_WIDTH exceeds rd_entry_t id field");
  end

  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic                 ovf_evt;
  logic                 last;
  logic [1:0]           resp_raw;
  logic [1:0]           resp;
  logic [7:0]           beat_cnt;
  logic [31:0]          lane_calc;
  logic [RD_ID_W-1:0]   head_id;
  rd_entry_t            din;
  rd_entry_t            head;

  assign push     = psel & penable & ~pwrite & pready;
  assign pop      = RVALID & RREADY;
  assign ovf_evt  = push & full & ~pop;
  assign rd_space = ~full;

  assign resp_raw  = cmd_err ? RESP_SLVERR : (pslverr ? RESP_DECERR : RESP_OKAY);
  assign last      = (beat_cnt == cmd_len);
  // Word index of the start address plus beat number, wrapped onto the bus lanes.
  assign lane_calc = (32'(cmd_addr >> 2) + 32'(beat_cnt)) % 32'(LANES);

`ifdef AXI2APB_RD_ERR_STICKY_EN
  logic       err_held;
  logic [1:0] err_resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_held <= 1'b0;
      err_resp <= RESP_OKAY;
    end else if (push) begin
      if (last) begin
        err_held <= 1'b0;
        err_resp <= RESP_OKAY;
      end else if (!err_held && resp_raw != RESP_OKAY) begin
        err_held <= 1'b1;
        err_resp <= resp_raw;
      end
    end
  end

  assign resp = err_held ? err_resp : resp_raw;
`else
  assign resp = resp_raw;
`endif

  assign din = '{id: RD_ID_W'(cmd_id), data: prdata, resp: resp, last: last,
                 lane: RD_LANE_W'(lane_calc)};

  always_ff @(posedge clk) begin
    if (rst) beat_cnt <= '0;
    else if (push) beat_cnt <= last ? 8'd0 : beat_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) rd_ovf <= 1'b0;
    else if (ovf_evt) rd_ovf <= 1'b1;
  end

  if (OVF_CHECK) begin : g_ovf_chk
    always_ff @(posedge clk) begin
      if (!rst) assert (!ovf_evt) else $error("axi2apb_rd_buf: read beat dropped, FIFO full");
    end
  end

  axi2apb_rd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  assign head_id   = head.id;
  assign RVALID    = ~empty;
  assign RID       = AXI_ID_WIDTH'(head_id);
  assign RRESP     = head.resp;
  assign RLAST     = head.last;
  assign finish_rd = RVALID & RREADY & RLAST;

  always_comb begin
    RDATA = '0;
    for (int i = 0; i < LANES; i++) begin
      if (head.lane == RD_LANE_W'(i)) RDATA[i*32 +: 32] = head.data;
    end
  end

endmodule

// File: tb/tb_axi2apb_rd_buf.sv
// Self-checking bench for axi2apb_rd_buf: directed scenarios plus randomized bursts vs a queue model.
module tb_axi2apb_rd_buf;

  localparam int IDW   = 6;
  localparam int DW    = 64;
  localparam int AW    = 12;
  localparam int DEPTH = 4;
  localparam int LANES = DW / 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            psel, penable, pwrite, pslverr, pready;
  logic [31:0]     prdata;
  logic            cmd_err;
  logic [IDW-1:0]  cmd_id;
  logic [AW+3:0]   cmd_addr;
  logic [7:0]      cmd_len;
  logic            rd_space, rd_ovf, finish_rd;
  logic [IDW-1:0]  RID;
  logic [DW-1:0]   RDATA;
  logic [1:0]      RRESP;
  logic            RLAST, RVALID, RREADY;

  always #5 clk = ~clk;

  axi2apb_rd_buf #(
    .AXI_ID_WIDTH(IDW), .AXI_DATA_WIDTH(DW), .APB_ADDR_WIDTH(AW), .DEPTH(DEPTH), .OVF_CHECK(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite), .prdata(prdata),
    .pslverr(pslverr), .pready(pready), .cmd_err(cmd_err), .cmd_id(cmd_id), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .rd_space(rd_space), .rd_ovf(rd_ovf), .finish_rd(finish_rd), .RID(RID),
    .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  typedef struct {
    logic [IDW-1:0] id;
    logic [DW-1:0]  data;
    logic [1:0]     resp;
    logic           last;
  } exp_t;

  exp_t       q[$];
  int         m_beat;
  logic       m_ovf;
  logic       m_stk_vld;
  logic [1:0] m_stk;
  int         log_lane[$];
  logic [1:0] log_resp[$];
  int         n_fin;
  int         n_chk = 0;
  int         n_err = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic compare_outputs();
    exp_t e;
    if (q.size() == 0) begin
      check_eq("rvalid_idle", RVALID, 0);
      check_eq("rdata_idle", RDATA, 0);
      check_eq("rid_idle", RID, 0);
      check_eq("rresp_idle", RRESP, 0);
      check_eq("rlast_idle", RLAST, 0);
      check_eq("finish_idle", finish_rd, 0);
    end else begin
      e = q[0];
      check_eq("rvalid", RVALID, 1);
      check_eq("rid", RID, e.id);
      check_eq("rdata", RDATA, e.data);
      check_eq("rresp", RRESP, e.resp);
      check_eq("rlast", RLAST, e.last);
      check_eq("finish_rd", finish_rd, RREADY & e.last);
      if (RREADY) begin
        log_lane.push_back(RDATA[63:32] != 0 ? 1 : 0);
        log_resp.push_back(RRESP);
        if (finish_rd === 1'b1) n_fin++;
      end
    end
    check_eq("rd_space", rd_space, q.size() < DEPTH);
    check_eq("rd_ovf", rd_ovf, m_ovf);
  endtask

  task automatic model_edge(input logic cap, input logic pop_now);
    logic [1:0] raw, resp;
    logic       last;
    int         lane;
    exp_t       e;
    if (rst) begin
      q.delete();
      m_beat = 0; m_ovf = 0; m_stk_vld = 0; m_stk = 0;
      return;
    end
    if (pop_now) void'(q.pop_front());
    if (cap) begin
      raw  = cmd_err ? 2'b10 : (pslverr ? 2'b11 : 2'b00);
      last = (m_beat == int'(cmd_len));
      lane = (int'(cmd_addr >> 2) + m_beat) % LANES;
      resp = raw;
`ifdef AXI2APB_RD_ERR_STICKY_EN
      if (m_stk_vld) resp = m_stk;
      if (last) m_stk_vld = 0;
      else if (!m_stk_vld && raw != 2'b00) begin m_stk_vld = 1; m_stk = raw; end
`endif
      e.id = cmd_id; e.resp = resp; e.last = last;
      e.data = DW'(prdata) << (32 * lane);
      if (q.size() < DEPTH) q.push_back(e);
      else m_ovf = 1;
      m_beat = last ? 0 : m_beat + 1;
    end
  endtask

  task automatic step();
    logic cap, pop_now;
    @(negedge clk);
    compare_outputs();
    cap     = psel & penable & ~pwrite & pready;
    pop_now = (q.size() > 0) && RREADY;
    @(posedge clk);
    model_edge(cap, pop_now);
    #1;
  endtask

  task automatic set_idle();
    psel = 0; penable = 0; pwrite = 0; pready = 0; pslverr = 0; prdata = $urandom;
  endtask

  task automatic apb_read(input logic [31:0] d, input logic err);
    psel = 1; penable = 1; pwrite = 0; pready = 1; prdata = d; pslverr = err;
    step();
    set_idle();
  endtask

  task automatic set_cmd(input logic [AW+3:0] a, input logic [7:0] l, input logic [IDW-1:0] id);
    cmd_addr = a; cmd_len = l; cmd_id = id; cmd_err = 0;
  endtask

  task automatic do_reset();
    rst = 1; step(); step(); rst = 0;
  endtask

  task automatic drain();
    RREADY = 1;
    for (int i = 0; i < DEPTH + 2; i++) step();
    RREADY = 0;
  endtask

  int         t2_lane[4] = '{0, 1, 0, 1};
`ifdef AXI2APB_RD_ERR_STICKY_EN
  logic [1:0] t3_resp[4] = '{2'b00, 2'b11, 2'b11, 2'b11};
`else
  logic [1:0] t3_resp[4] = '{2'b00, 2'b11, 2'b00, 2'b00};
`endif

  initial begin
    rst = 1; RREADY = 0; set_idle(); set_cmd('0, 8'd0, '0);
    m_beat = 0; m_ovf = 0; m_stk_vld = 0; m_stk = 0; n_fin = 0;
    step(); step(); rst = 0;
    step();

    // single read into the upper lane
    set_cmd(16'h004, 8'd0, 6'd5);
    apb_read(32'hDEADBEEF, 0);
    check_eq("t1_rvalid", RVALID, 1);
    check_eq("t1_rdata", RDATA, 64'hDEADBEEF_00000000);
    check_eq("t1_rlast", RLAST, 1);
    check_eq("t1_rresp", RRESP, 0);
    drain();

    // burst buffered under backpressure, then drained
    set_cmd(16'h000, 8'd3, 6'd9);
    for (int i = 0; i < 4; i++) apb_read(32'h1000_0000 + i, 0);
    check_eq("t2_space", rd_space, 0);
    log_lane.delete(); n_fin = 0;
    drain();
    check_eq("t2_npop", log_lane.size(), 4);
    for (int i = 0; i < 4; i++) check_eq($sformatf("t2_lane%0d", i), log_lane[i], t2_lane[i]);
    check_eq("t2_finish", n_fin, 1);

    // error on beat 1
    set_cmd(16'h000, 8'd3, 6'd3);
    log_resp.delete();
    RREADY = 1;
    for (int i = 0; i < 4; i++) begin
      psel = 1; penable = 1; pwrite = 0; pready = 1; prdata = 32'h2000_0000 + i; pslverr = (i == 1);
      step();
    end
    set_idle();
    drain();
    check_eq("t3_npop", log_resp.size(), 4);
    for (int i = 0; i < 4; i++) check_eq($sformatf("t3_resp%0d", i), log_resp[i], t3_resp[i]);

    // full FIFO with push and pop together
    set_cmd(16'h000, 8'd7, 6'd11);
    for (int i = 0; i < 4; i++) apb_read(32'h3000_0000 + i, 0);
    RREADY = 1;
    apb_read(32'h3000_0004, 0);
    RREADY = 0;
    check_eq("t4_full", rd_space, 0);
    check_eq("t4_ovf", rd_ovf, 0);
    RREADY = 1;
    for (int i = 5; i < 8; i++) apb_read(32'h3000_0000 + i, 0);
    drain();

    // overflow while full and stalled
    set_cmd(16'h004, 8'd7, 6'd12);
    for (int i = 0; i < 5; i++) apb_read(32'h4000_0000 + i, 0);
    check_eq("t5_ovf", rd_ovf, 1);
    step(); step();
    drain();
    check_eq("t5_ovf_hold", rd_ovf, 1);
    do_reset();
    step();
    check_eq("t5_ovf_clr", rd_ovf, 0);

    // reset in the middle of a long burst
    set_cmd(16'h004, 8'd7, 6'd13);
    for (int i = 0; i < 3; i++) apb_read(32'h5000_0000 + i, 0);
    do_reset();
    check_eq("t6_rvalid", RVALID, 0);
    check_eq("t6_space", rd_space, 1);
    apb_read(32'h5A5A_0001, 0);
    check_eq("t6_lane", RDATA, 64'h5A5A0001_00000000);
    check_eq("t6_rlast", RLAST, 0);
    drain();
    do_reset();

    // randomized bursts
    for (int b = 0; b < 200; b++) begin
      cmd_id = IDW'($urandom); cmd_addr = 16'($urandom); cmd_len = 8'($urandom_range(0, 7));
      cmd_err = ($urandom_range(0, 9) == 0);
      for (int k = 0; k <= int'(cmd_len); ) begin
        RREADY = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 3) != 0 && (q.size() < DEPTH || (RREADY && q.size() > 0))) begin
          psel = 1; penable = 1; pwrite = 0; pready = 1;
          prdata = $urandom; pslverr = ($urandom_range(0, 5) == 0);
          k++;
        end else begin
          psel = 1'($urandom); penable = 1'($urandom); pwrite = 1'($urandom);
          pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
          if (psel && penable && pready) pwrite = 1;
        end
        step();
      end
    end
    set_idle();
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
